// File: rtl/wb_pl_arbiter.sv
// N-master to 1-slave round-robin arbiter for pipelined Wishbone B4.
// Routes the owner's request to the slave and steers responses back, limiting outstanding requests.
module wb_pl_arbiter #(
  parameter int NM      = 2,
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int SEL_W   = DAT_W / 8,
  parameter int MAX_OUT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // master side
  input  logic [NM*ADR_W-1:0] m_adr,
  input  logic [NM*DAT_W-1:0] m_dat_mo,
  input  logic [NM*SEL_W-1:0] m_sel,
  input  logic [NM-1:0]       m_cyc,
  input  logic [NM-1:0]       m_stb,
  input  logic [NM-1:0]       m_we,
  output logic [DAT_W-1:0]    m_dat_so,
  output logic [NM-1:0]       m_ack,
  output logic [NM-1:0]       m_err,
  output logic [NM-1:0]       m_rty,
  output logic [NM-1:0]       m_stall,
  // slave side
  output logic [ADR_W-1:0]    s_adr,
  output logic [DAT_W-1:0]    s_dat_mo,
  output logic [SEL_W-1:0]    s_sel,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  input  logic [DAT_W-1:0]    s_dat_so,
  input  logic                s_ack,
  input  logic                s_err,
  input  logic                s_rty,
  input  logic                s_stall,
  // observability
  output logic [NM-1:0]       gnt
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = 4;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [IW-1:0] last_gnt_reg, last_gnt_next;
  logic [CW-1:0] out_cnt_reg, out_cnt_next;

  logic [IW-1:0] pick;
  logic          any_req;
  logic          busy;
  logic          own_cyc;
  logic          full;
  logic          accept;
  logic          resp_ok;
  logic          resp;

  // Index of the master that sits 'off' places after 'base' in the ring.
  function automatic logic [IW-1:0] ring_idx(input logic [IW-1:0] base, input int off);
    int idx;
    idx = int'(base) + off;
    if (idx >= NM) idx = idx - NM;
    return IW'(idx);
  endfunction

  // Walk the ring from farthest to nearest so the nearest requester after last_gnt wins.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int i = NM; i >= 1; i--) begin
      if (m_cyc[ring_idx(last_gnt_reg, i)]) begin
        pick    = ring_idx(last_gnt_reg, i);
        any_req = 1'b1;
      end
    end
  end

  assign busy    = (state_reg == BUSY) && !rst_i;
  assign own_cyc = busy && m_cyc[owner_reg];
  assign full    = (out_cnt_reg == MAX_CNT);

  // Request path to the slave, muxed from the current owner.
  assign s_adr    = m_adr[int'(owner_reg)*ADR_W +: ADR_W];
  assign s_dat_mo = m_dat_mo[int'(owner_reg)*DAT_W +: DAT_W];
  assign s_sel    = m_sel[int'(owner_reg)*SEL_W +: SEL_W];
  assign s_we     = m_we[owner_reg];
  assign s_cyc    = own_cyc;
  assign s_stb    = own_cyc && m_stb[owner_reg] && !full;

  assign accept   = s_stb && !s_stall;
  // Responses only count while something is outstanding; stray ones are dropped.
  assign resp_ok  = own_cyc && (out_cnt_reg != '0);
  assign resp     = resp_ok && (s_ack || s_err || s_rty);

  assign m_dat_so = s_dat_so;

  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_master
      logic is_owner;
      assign is_owner    = busy && (owner_reg == IW'(gi));
      assign gnt[gi]     = is_owner;
      assign m_ack[gi]   = is_owner && resp_ok && s_ack;
      assign m_err[gi]   = is_owner && resp_ok && s_err;
      assign m_rty[gi]   = is_owner && resp_ok && s_rty;
      assign m_stall[gi] = is_owner ? (s_stall || full) : 1'b1;
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    last_gnt_next = last_gnt_reg;
    out_cnt_next  = out_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = BUSY;
          owner_next = pick;
        end
      end
      BUSY: begin
        if (!m_cyc[owner_reg]) begin
          // Owner abandoned the cycle: forget anything still in flight.
          state_next    = IDLE;
          last_gnt_next = owner_reg;
          out_cnt_next  = '0;
        end else if (accept && !resp && !full) begin
          out_cnt_next = out_cnt_reg + 1'b1;
        end else if (resp && !accept && (out_cnt_reg != '0)) begin
          out_cnt_next = out_cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      last_gnt_reg <= IW'(NM - 1);
      out_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      last_gnt_reg <= last_gnt_next;
      out_cnt_reg  <= out_cnt_next;
    end
  end

endmodule

// File: tb/tb_wb_pl_arbiter.sv
// Bench for wb_pl_arbiter: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural owner/queue-depth model.
module tb_wb_pl_arbiter;

  localparam int NM      = 3;
  localparam int ADR_W   = 16;
  localparam int DAT_W   = 16;
  localparam int SEL_W   = DAT_W / 8;
  localparam int MAX_OUT = 3;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [NM*ADR_W-1:0] m_adr;
  logic [NM*DAT_W-1:0] m_dat_mo;
  logic [NM*SEL_W-1:0] m_sel;
  logic [NM-1:0]       m_cyc, m_stb, m_we;
  logic [DAT_W-1:0]    m_dat_so;
  logic [NM-1:0]       m_ack, m_err, m_rty, m_stall;
  logic [ADR_W-1:0]    s_adr;
  logic [DAT_W-1:0]    s_dat_mo;
  logic [SEL_W-1:0]    s_sel;
  logic                s_cyc, s_stb, s_we;
  logic [DAT_W-1:0]    s_dat_so;
  logic                s_ack, s_err, s_rty, s_stall;
  logic [NM-1:0]       gnt;

  wb_pl_arbiter #(
    .NM(NM), .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_adr(m_adr), .m_dat_mo(m_dat_mo), .m_sel(m_sel),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_dat_so(m_dat_so), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_stall(m_stall),
    .s_adr(s_adr), .s_dat_mo(s_dat_mo), .s_sel(s_sel),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_dat_so(s_dat_so), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_stall(s_stall),
    .gnt(gnt)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // model: current owner (-1 = none), last owner, outstanding request count
  int owner = -1;
  int last  = NM - 1;
  int cnt   = 0;

  logic [63:0] obs_gnt, obs_ack, obs_err, obs_stall, obs_s_stb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Called at posedge+1 with inputs already applied; checks mid-cycle, then advances.
  task automatic tick();
    bit busy, scyc, full, sstb, acc, rok, rsp;
    logic [NM-1:0] e_gnt, e_ack, e_err, e_rty, e_stall;
    #4;
    busy = (owner >= 0) && !rst_i;
    scyc = busy && m_cyc[owner];
    full = (cnt == MAX_OUT);
    sstb = scyc && m_stb[owner] && !full;
    acc  = sstb && !s_stall;
    rok  = scyc && (cnt > 0);
    rsp  = rok && (s_ack || s_err || s_rty);
    for (int k = 0; k < NM; k++) begin
      e_gnt[k]   = busy && (k == owner);
      e_ack[k]   = e_gnt[k] && rok && s_ack;
      e_err[k]   = e_gnt[k] && rok && s_err;
      e_rty[k]   = e_gnt[k] && rok && s_rty;
      e_stall[k] = e_gnt[k] ? (s_stall || full) : 1'b1;
    end
    chk("s_cyc",   64'(s_cyc),   64'(scyc));
    chk("s_stb",   64'(s_stb),   64'(sstb));
    chk("gnt",     64'(gnt),     64'(e_gnt));
    chk("m_ack",   64'(m_ack),   64'(e_ack));
    chk("m_err",   64'(m_err),   64'(e_err));
    chk("m_rty",   64'(m_rty),   64'(e_rty));
    chk("m_stall", 64'(m_stall), 64'(e_stall));
    chk("m_dat_so", 64'(m_dat_so), 64'(s_dat_so));
    if (busy) begin
      chk("s_adr",    64'(s_adr),    64'(m_adr[owner*ADR_W +: ADR_W]));
      chk("s_dat_mo", 64'(s_dat_mo), 64'(m_dat_mo[owner*DAT_W +: DAT_W]));
      chk("s_sel",    64'(s_sel),    64'(m_sel[owner*SEL_W +: SEL_W]));
      chk("s_we",     64'(s_we),     64'(m_we[owner]));
    end
    obs_gnt = 64'(gnt); obs_ack = 64'(m_ack); obs_err = 64'(m_err);
    obs_stall = 64'(m_stall); obs_s_stb = 64'(s_stb);
    if (rst_i) begin
      owner = -1; last = NM - 1; cnt = 0;
    end else if (owner < 0) begin
      for (int i = 1; i <= NM; i++) begin
        if (m_cyc[(last + i) % NM]) begin
          owner = (last + i) % NM;
          break;
        end
      end
    end else if (!m_cyc[owner]) begin
      last = owner; owner = -1; cnt = 0;
    end else begin
      cnt = cnt + int'(acc) - int'(rsp);
    end
    @(posedge clk_i);
    #1;
    cycle++;
  endtask

  task automatic randomize_data();
    for (int k = 0; k < NM; k++) begin
      m_adr[k*ADR_W +: ADR_W]    = ADR_W'($urandom);
      m_dat_mo[k*DAT_W +: DAT_W] = DAT_W'($urandom);
      m_sel[k*SEL_W +: SEL_W]    = SEL_W'($urandom);
    end
    s_dat_so = DAT_W'($urandom);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_stall = 1'b0;
    randomize_data();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    m_cyc = '1; m_stb = '1;
    tick();
    chk("rst_stall", obs_stall, 64'h7);
    chk("rst_gnt", obs_gnt, 64'h0);
    clear_inputs();
    tick();
    rst_i = 1'b0;
  endtask

  int n;

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    @(posedge clk_i);
    #1;

    // 1: master 0, three back-to-back reads, acks two cycles after each strobe
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick(); chk("t1_idle_stb", obs_s_stb, 64'd0);
    tick(); chk("t1_gnt", obs_gnt, 64'h1); chk("t1_stb", obs_s_stb, 64'd1);
    tick();
    s_ack = 1'b1;
    tick(); chk("t1_ack_a", obs_ack, 64'h1);
    m_stb[0] = 1'b0;
    tick(); chk("t1_ack_b", obs_ack, 64'h1);
    tick(); chk("t1_ack_c", obs_ack, 64'h1);
    s_ack = 1'b0; m_cyc[0] = 1'b0;
    tick();
    tick(); chk("t1_idle_gnt", obs_gnt, 64'h0);

    // 2: simultaneous requests, round-robin hand-over through one IDLE cycle
    do_reset();
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    tick();
    tick(); chk("t2_gnt0", obs_gnt, 64'h1);
    m_stb[0] = 1'b0; s_ack = 1'b1;
    tick(); chk("t2_ack", obs_ack, 64'h1); chk("t2_stall1", 64'(obs_stall[1]), 64'd1);
    s_ack = 1'b0; m_cyc[0] = 1'b0;
    tick();
    tick(); chk("t2_idle", obs_gnt, 64'h0);
    tick(); chk("t2_gnt1", obs_gnt, 64'h2);
    m_cyc[1] = 1'b0;
    tick();
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    tick();
    tick(); chk("t2_gnt0_again", obs_gnt, 64'h1);

    // 3: stream strobes with no acks until the outstanding limit is hit
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(obs_s_stb);
    end
    chk("t3_accepts", 64'(n), 64'(MAX_OUT));
    chk("t3_full_stall", 64'(obs_stall[0]), 64'd1);
    s_ack = 1'b1;
    tick(); chk("t3_ack", obs_ack, 64'h1);
    s_ack = 1'b0;
    tick(); chk("t3_unstall", 64'(obs_stall[0]), 64'd0); chk("t3_restb", obs_s_stb, 64'd1);

    // 4: accept and ack together at depth 1, then a stray ack is dropped
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    tick();
    s_ack = 1'b1;
    tick(); chk("t4_ack_acc", obs_ack, 64'h1);
    m_stb[0] = 1'b0;
    tick(); chk("t4_ack_last", obs_ack, 64'h1);
    tick(); chk("t4_stray_ack", obs_ack, 64'h0);
    s_ack = 1'b0;

    // 5: owner aborts with two outstanding; late ack goes nowhere
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    tick();
    tick();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();
    s_ack = 1'b1;
    tick(); chk("t5_late_ack", obs_ack, 64'h0); chk("t5_idle", obs_gnt, 64'h0);
    s_ack = 1'b0;

    // 6: error for master 1 while master 0 waits
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick(); chk("t6_gnt1", obs_gnt, 64'h2); chk("t6_stall0_a", 64'(obs_stall[0]), 64'd1);
    m_stb[1] = 1'b0;
    tick(); chk("t6_stall0_b", 64'(obs_stall[0]), 64'd1);
    s_err = 1'b1;
    tick(); chk("t6_err", obs_err, 64'h2); chk("t6_stall0_c", 64'(obs_stall[0]), 64'd1);
    s_err = 1'b0; m_cyc[1] = 1'b0;
    tick();
    tick();
    tick(); chk("t6_gnt0", obs_gnt, 64'h1);

    // random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_i = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(0, 7) == 0) m_cyc[k] = ~m_cyc[k];
        m_stb[k] = m_cyc[k] && ($urandom_range(0, 2) != 0);
        m_we[k]  = 1'($urandom);
      end
      randomize_data();
      s_stall = ($urandom_range(0, 3) == 0);
      s_ack   = ($urandom_range(0, 9) < 4);
      s_err   = ($urandom_range(0, 9) == 0);
      s_rty   = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_pl_arbiter.md
Name: wb_pl_arbiter

Overview:
- N-master to 1-slave arbiter for pipelined Wishbone B4 (pl_master/pl_slave signal set), parametrised in address/data width and master count.
- Round-robin bus ownership, per-master response routing and a bounded outstanding-request counter.
- Sits between CPU/DMA masters and the shared system-bus slave; generalises the single point-to-point pipelined link to a shared bus.

Parameters:
- NM, 2, number of masters (2..8)
- ADR_W, 32, address width
- DAT_W, 32, data width
- SEL_W, DAT_W/8, byte-select width
- MAX_OUT, 4, max accepted-but-unanswered requests (1..15)

Ports:
- clk_i  in  1  bus clock
- rst_i  in  1  synchronous active-high reset
- m_adr  in  NM*ADR_W  master addresses, master k at slice k
- m_dat_mo  in  NM*DAT_W  master write data
- m_sel  in  NM*SEL_W  master byte selects
- m_cyc, m_stb, m_we  in  NM each  master cycle/strobe/write
- m_dat_so  out  DAT_W  read data, broadcast to all masters
- m_ack, m_err, m_rty, m_stall  out  NM each  per-master response/stall
- s_adr, s_dat_mo, s_sel  out  ADR_W/DAT_W/SEL_W  to slave
- s_cyc, s_stb, s_we  out  1 each  to slave
- s_dat_so  in  DAT_W  slave read data
- s_ack, s_err, s_rty, s_stall  in  1 each  slave response/stall
- gnt  out  NM  one-hot current owner (debug/observability)

Behaviour:
- Reset: state IDLE, gnt=0, last_gnt=NM-1 so master 0 wins first, out_cnt=0. Outputs during reset: s_cyc=0, s_stb=0, m_ack/m_err/m_rty=0, m_stall=all-ones.
- FSM:
  - IDLE: if any m_cyc, next cycle gnt = first requester after last_gnt (cyclic), go BUSY; else stay. Arbitration latency 1 cycle: a master raising cyc in cycle t sees its first possible acceptance in cycle t+1.
  - BUSY: owner g fixed. When m_cyc[g]=0: next cycle gnt=0, last_gnt=g, out_cnt=0, state IDLE (abort semantics; late slave responses dropped).
  - No preemption.
- Datapath, combinational from gnt: s_adr/s_dat_mo/s_sel/s_we = slice g; s_cyc = m_cyc[g] in BUSY, else 0.
- Strobe gating: s_stb = m_stb[g] and not full, where full = (out_cnt==MAX_OUT).
- Stall: m_stall[g] = s_stall or full. Non-owners: m_stall=1, m_ack/m_err/m_rty=0.
- Accept = s_stb and not s_stall.
- Responses: resp = s_ack|s_err|s_rty, forwarded to m_*[g] only when out_cnt>0. A response with out_cnt==0 is dropped.
- out_cnt update: accept and no resp: +1; resp and no accept: -1; both: unchanged. Never exceeds MAX_OUT or wraps below 0.
- m_dat_so = s_dat_so unconditionally.
- Simultaneous ack and err from slave: both forwarded as-is; counter decrements once.
- Owner drops cyc while out_cnt>0: counter cleared, no responses forwarded afterwards.

Test Plan:
- Single master 0, 3 back-to-back reads, slave stall=0, ack 2 cycles later each -> cyc at t, s_stb t+1..t+3, m_ack[0] at t+3..t+5, out_cnt peaks at 2, returns 0.
- Masters 0 and 1 raise cyc same cycle; 0 runs 1 write, drops cyc -> gnt=01, then IDLE for 1 cycle, then gnt=10; next simultaneous request goes to 0 again.
- MAX_OUT=2, master streams 4 strobes, slave never acks -> s_stb on 2 accepts only, m_stall[g]=1 from the third; first ack lowers m_stall next cycle.
- Accept and ack in the same cycle with out_cnt=1 -> out_cnt stays 1, m_ack[g]=1.
- Owner drops cyc with out_cnt=2, slave acks next cycle -> no m_ack to any master, out_cnt=0, state IDLE.
- s_err pulse for master 1 while master 0 requests -> m_err[1]=1, m_err[0]=0, m_stall[0]=1 throughout master 1's tenure.
